packet_switch_avmm_cmd_master: RTL and testbench

- AVMM initiator that turns a valid/ready command stream into single AVMM read or write transactions toward packet-switch CSR responders, such as the DMA RX demux drop-enable/threshold CSR space.
- Reads complete on readdata_valid. A read that gets no return is bounded by a timeout and reported as an error.
- Sits between a management/host command source and the CSR responder's AVMM port. One transaction is in flight at a time.

---
 rtl/packet_switch_avmm_cmd_master.sv | 139 +++++++++++++
 tb/tb_packet_switch_avmm_cmd_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_switch_avmm_cmd_master.sv
// AVMM initiator for packet-switch CSR windows: one command in flight, turned
// into a single-cycle AVMM read or write, with window range check and read timeout.
module packet_switch_avmm_cmd_master #(
  parameter int unsigned BASE_ADDR      = 'h0,
  parameter int unsigned MAX_ADDR       = 'h10,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_address,
  input  logic [DATA_WIDTH-1:0]   cmd_writedata,
  input  logic [DATA_WIDTH/8-1:0] cmd_byteenable,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic                    rsp_error,
  output logic [DATA_WIDTH-1:0]   rsp_readdata,
  output logic [ADDR_WIDTH-1:0]   avmm_address,
  output logic                    avmm_read,
  output logic                    avmm_write,
  output logic [DATA_WIDTH-1:0]   avmm_writedata,
  output logic [DATA_WIDTH/8-1:0] avmm_byteenable,
  input  logic [DATA_WIDTH-1:0]   avmm_readdata,
  input  logic                    avmm_readdata_valid,
  output logic [15:0]             stat_rd_timeout_cnt,
  output logic [15:0]             stat_stray_rdv_cnt
);

  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0]   WIN_BASE = (ADDR_WIDTH + 1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   WIN_SIZE = (ADDR_WIDTH + 1)'(MAX_ADDR);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_RSP     = 2'd3;

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [ADDR_WIDTH:0]  addr_off;
  logic                 in_range;
  logic                 accept;

  // Offset compare at ADDR_WIDTH+1 bits: addresses below the base wrap to
  // offsets >= 2**ADDR_WIDTH, so one unsigned compare covers both bounds.
  assign addr_off = {1'b0, cmd_address} - WIN_BASE;
  assign in_range = (addr_off < WIN_SIZE);
  assign accept   = (state == S_IDLE) && cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      wait_cnt            <= '0;
      cmd_ready           <= 1'b0;
      rsp_valid           <= 1'b0;
      rsp_write           <= 1'b0;
      rsp_error           <= 1'b0;
      rsp_readdata        <= '0;
      avmm_address        <= '0;
      avmm_read           <= 1'b0;
      avmm_write          <= 1'b0;
      avmm_writedata      <= '0;
      avmm_byteenable     <= '0;
      stat_rd_timeout_cnt <= '0;
      stat_stray_rdv_cnt  <= '0;
    end else begin
      avmm_read  <= 1'b0;
      avmm_write <= 1'b0;

      if (avmm_readdata_valid && (state != S_WAIT_RD) && (stat_stray_rdv_cnt != 16'hFFFF))
        stat_stray_rdv_cnt <= stat_stray_rdv_cnt + 16'd1;

      case (state)
        S_IDLE: begin
          cmd_ready <= !accept;
          if (accept) begin
            rsp_write       <= cmd_write;
            avmm_address    <= cmd_address;
            avmm_writedata  <= cmd_writedata;
            avmm_byteenable <= cmd_byteenable;
            if (in_range) begin
              state      <= S_ISSUE;
              avmm_read  <= !cmd_write;
              avmm_write <= cmd_write;
            end else begin
              state        <= S_RSP;
              rsp_valid    <= 1'b1;
              rsp_error    <= 1'b1;
              rsp_readdata <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (rsp_write) begin
            state        <= S_RSP;
            rsp_valid    <= 1'b1;
            rsp_error    <= 1'b0;
            rsp_readdata <= '0;
          end else begin
            state    <= S_WAIT_RD;
            wait_cnt <= '0;
          end
        end
        S_WAIT_RD: begin
          if (avmm_readdata_valid) begin
            state        <= S_RSP;
            rsp_valid    <= 1'b1;
            rsp_error    <= 1'b0;
            rsp_readdata <= avmm_readdata;
          end else if (wait_cnt == CNT_LAST) begin
            state        <= S_RSP;
            rsp_valid    <= 1'b1;
            rsp_error    <= 1'b1;
            rsp_readdata <= '0;
            if (stat_rd_timeout_cnt != 16'hFFFF)
              stat_rd_timeout_cnt <= stat_rd_timeout_cnt + 16'd1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_switch_avmm_cmd_master.sv
// Bench for packet_switch_avmm_cmd_master: random commands against a
// transaction-level model, with queued expectations checked by separate monitors.
module tb_packet_switch_avmm_cmd_master;
  localparam int AW     = 8;
  localparam int DW     = 32;
  localparam int BASE   = 'h0;
  localparam int MAXA   = 'h10;
  localparam int T      = 64;
  localparam int BP_IDX = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [DW-1:0] cmd_writedata = '0;
  logic [3:0]    cmd_byteenable = '0;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_error;
  logic [DW-1:0] rsp_readdata;
  logic [AW-1:0] avmm_address;
  logic          avmm_read, avmm_write;
  logic [DW-1:0] avmm_writedata;
  logic [3:0]    avmm_byteenable;
  logic [DW-1:0] avmm_readdata;
  logic          avmm_readdata_valid;
  logic [15:0]   stat_rd_timeout_cnt, stat_stray_rdv_cnt;

  packet_switch_avmm_cmd_master #(
    .BASE_ADDR(BASE), .MAX_ADDR(MAXA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata), .cmd_byteenable(cmd_byteenable),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_error(rsp_error), .rsp_readdata(rsp_readdata),
    .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
    .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
    .avmm_readdata(avmm_readdata), .avmm_readdata_valid(avmm_readdata_valid),
    .stat_rd_timeout_cnt(stat_rd_timeout_cnt), .stat_stray_rdv_cnt(stat_stray_rdv_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic wr; logic err; logic [DW-1:0] data; int cyc; } rsp_t;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [3:0] be; int cyc; } av_t;
  typedef struct { int lat; logic [DW-1:0] data; } rd_t;

  rsp_t rsp_q[$];
  av_t  av_q[$];
  rd_t  rd_q[$];

  int checks = 0;
  int failures = 0;
  int exp_to = 0;
  int exp_stray = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Expected outcome of one command, derived from the window/timeout rules.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [3:0] be, input int lat, input bit exp_rsp);
    int   n = 0;
    int   a;
    bit   inr;
    rsp_t r;
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr;
    cmd_writedata = data; cmd_byteenable = be;
    while (!cmd_ready) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        check("cmd_accept_timeout", 64'd0, 64'd1);
        finish_now();
      end
    end
    a   = cyc;
    inr = (int'(addr) >= BASE) && (int'(addr) < BASE + MAXA);
    r.wr = wr;
    if (!inr)                    begin r.err = 1'b1; r.data = '0;   r.cyc = a + 1; end
    else if (wr)                 begin r.err = 1'b0; r.data = '0;   r.cyc = a + 2; end
    else if (lat >= 1 && lat <= T) begin r.err = 1'b0; r.data = data; r.cyc = a + lat + 2; end
    else begin
      r.err = 1'b1; r.data = '0; r.cyc = a + T + 2;
      exp_to++;
      if (lat > T) exp_stray++;
    end
    if (exp_rsp) rsp_q.push_back(r);
    if (inr) av_q.push_back('{wr, addr, data, be, a + 1});
    if (inr && !wr) rd_q.push_back('{lat, data});
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_address = AW'($urandom);
    cmd_writedata = $urandom; cmd_byteenable = 4'($urandom);
    if (inr && !wr && lat > T) repeat (lat + 4) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rsp_q.size() != 0 || rsp_valid || !cmd_ready) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        check("idle_wait_timeout", 64'd0, 64'd1);
        finish_now();
      end
    end
    check("stat_rd_timeout_cnt", 64'(stat_rd_timeout_cnt), 64'(exp_to));
    check("stat_stray_rdv_cnt", 64'(stat_stray_rdv_cnt), 64'(exp_stray));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 64'({cmd_ready, rsp_valid, rsp_write, rsp_error, avmm_read, avmm_write,
                               avmm_address, avmm_byteenable, stat_rd_timeout_cnt, stat_stray_rdv_cnt}), 64'd0);
    check({tag, "_data"}, {rsp_readdata, avmm_writedata}, 64'd0);
  endtask

  // Responder: returns read data a chosen number of cycles after the strobe (0 = never).
  initial begin
    rd_t d;
    avmm_readdata_valid = 1'b0;
    avmm_readdata = '0;
    forever begin
      @(negedge clk);
      avmm_readdata = $urandom;
      if (!rst && avmm_read && rd_q.size() != 0) begin
        d = rd_q.pop_front();
        if (d.lat > 0) begin
          repeat (d.lat) @(negedge clk);
          avmm_readdata_valid = 1'b1;
          avmm_readdata = d.data;
          @(negedge clk);
          avmm_readdata_valid = 1'b0;
          avmm_readdata = $urandom;
        end
      end
    end
  end

  // AVMM strobe monitor.
  initial begin
    av_t v;
    forever begin
      @(negedge clk);
      if (!rst && (avmm_read || avmm_write)) begin
        if (av_q.size() == 0) begin
          check("unexpected_avmm_strobe", 64'd1, 64'd0);
        end else begin
          v = av_q.pop_front();
          check("avmm_both_strobes", 64'(avmm_read & avmm_write), 64'd0);
          check("avmm_write_dir", 64'(avmm_write), 64'(v.wr));
          check("avmm_address", 64'(avmm_address), 64'(v.addr));
          check("avmm_strobe_cycle", 64'(cyc), 64'(v.cyc));
          if (v.wr) begin
            check("avmm_writedata", 64'(avmm_writedata), 64'(v.data));
            check("avmm_byteenable", 64'(avmm_byteenable), 64'(v.be));
          end
        end
      end
    end
  end

  // Response monitor and rsp_ready driver.
  initial begin
    rsp_t e;
    bit   have = 0, hs_prev = 0;
    int   hold_left = 0, nresp = 0;
    logic [DW+1:0] cur = '0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have = 0; hs_prev = 0; rsp_ready = 1'b0;
      end else begin
        if (hs_prev) begin
          check("cmd_ready_after_handshake", 64'(cmd_ready), 64'd1);
          check("rsp_valid_after_handshake", 64'(rsp_valid), 64'd0);
        end
        hs_prev = 0;
        if (rsp_valid) begin
          check("cmd_ready_during_rsp", 64'(cmd_ready), 64'd0);
          if (!have) begin
            if (rsp_q.size() == 0) begin
              check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
              e = rsp_q.pop_front();
              check("rsp_write", 64'(rsp_write), 64'(e.wr));
              check("rsp_error", 64'(rsp_error), 64'(e.err));
              check("rsp_readdata", 64'(rsp_readdata), 64'(e.data));
              check("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
            cur  = {rsp_write, rsp_error, rsp_readdata};
            have = 1;
            nresp++;
            hold_left = (nresp == BP_IDX) ? 10 : int'($urandom_range(0, 2));
          end else begin
            check("rsp_stable", 64'({rsp_write, rsp_error, rsp_readdata}), 64'(cur));
          end
          if (hold_left == 0) begin
            rsp_ready = 1'b1; hs_prev = 1; have = 0;
          end else begin
            rsp_ready = 1'b0; hold_left--;
          end
        end else begin
          rsp_ready = 1'($urandom);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    check("global_timeout", 64'd0, 64'd1);
    finish_now();
  end

  initial begin
    logic          wr;
    logic [AW-1:0] addr;
    int            lat, sel;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    do_cmd(1'b1, 8'h02, 32'h0000_0001, 4'hF, 0, 1);
    do_cmd(1'b0, 8'h04, 32'h0000_1234, 4'hF, 3, 1);
    do_cmd(1'b1, 8'h05, 32'hA5A5_0F0F, 4'h6, 0, 1);
    wait_idle();
    do_cmd(1'b0, 8'h06, 32'hDEAD_BEEF, 4'hF, T + 3, 1);
    wait_idle();
    do_cmd(1'b1, 8'h10, 32'h1111_2222, 4'hF, 0, 1);
    do_cmd(1'b0, 8'hFF, 32'h3333_4444, 4'hF, 1, 1);
    do_cmd(1'b0, 8'h0F, 32'h5555_6666, 4'hF, T, 1);
    do_cmd(1'b0, 8'h00, 32'h7777_8888, 4'hF, 1, 1);
    do_cmd(1'b0, 8'h01, 32'h9999_AAAA, 4'hF, T + 1, 1);
    wait_idle();

    do_cmd(1'b0, 8'h03, 32'hCAFE_F00D, 4'hF, 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset_outputs");
    rst = 1'b0;
    exp_to = 0;
    exp_stray = 0;
    @(negedge clk);
    check("cmd_ready_after_mid_reset", 64'(cmd_ready), 64'd1);
    do_cmd(1'b0, 8'h07, 32'h0BAD_C0DE, 4'hF, 2, 1);
    wait_idle();

    for (int i = 0; i < 150; i++) begin
      wr   = 1'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(16, 255)) : AW'($urandom_range(0, 15));
      sel  = int'($urandom_range(0, 19));
      if (sel == 0)      lat = T + int'($urandom_range(1, 6));
      else if (sel == 1) lat = T;
      else               lat = int'($urandom_range(1, 8));
      do_cmd(wr, addr, $urandom, 4'($urandom), lat, 1);
      if (i % 10 == 9) wait_idle();
    end
    wait_idle();
    check("scoreboard_av_empty", 64'(av_q.size()), 64'd0);
    finish_now();
  end

endmodule
